// File: rtl/debug_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : debug_led_pattern_gen
// Brief    : Multi-channel debug LED driver: off / on / blink / blink-code
//            per channel, driven from a divided-down base tick.
// Revision : 1.0 - initial release
// ============================================================================
module debug_led_pattern_gen #(
    parameter int CLK_HZ    = 1_000_000,
    parameter int TICK_HZ   = 8,
    parameter int N_LEDS    = 4,
    parameter int GAP_TICKS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2*N_LEDS-1:0]   mode,
    input  logic [4*N_LEDS-1:0]   code,
    output logic [N_LEDS-1:0]     led,
    output logic                  tick
);

    localparam int c_DIV = CLK_HZ / TICK_HZ;
    localparam int c_PW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_GW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(c_DIV - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    logic [c_PW-1:0]     r_prescaler;
    logic                r_tick;
    logic [2:0]          r_phase;
    logic [2*N_LEDS-1:0] r_mode;

    // Mode is staged once so every channel sees a clean registered copy;
    // a mode change therefore reaches the LED on the second edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prescaler <= '0;
            r_tick      <= 1'b0;
            r_phase     <= '0;
            r_mode      <= '0;
        end else begin
            r_prescaler <= (r_prescaler == c_PRE_LAST) ? '0 : r_prescaler + c_PW'(1);
            r_tick      <= (r_prescaler == c_PRE_LAST);
            if (r_tick) begin
                r_phase <= r_phase + 3'd1;
            end
            r_mode      <= mode;
        end
    end

    assign tick = r_tick;

    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_chan
            state_t          r_state;
            state_t          w_state_nx;
            logic [3:0]      r_pulse_cnt;
            logic [3:0]      w_pulse_cnt_nx;
            logic [3:0]      r_code_lat;
            logic [3:0]      w_code_lat_nx;
            logic [c_GW-1:0] r_gap_cnt;
            logic [c_GW-1:0] w_gap_cnt_nx;
            logic            w_restart;
            logic            w_led_nx;
            logic            r_led;
            logic [1:0]      w_mode;
            logic [3:0]      w_code;

            assign w_mode = r_mode[2*gi +: 2];
            assign w_code = code[4*gi +: 4];

            always_comb begin
                w_state_nx     = r_state;
                w_pulse_cnt_nx = r_pulse_cnt;
                w_code_lat_nx  = r_code_lat;
                w_gap_cnt_nx   = r_gap_cnt;
                w_restart      = 1'b0;

                if (w_mode != 2'b11) begin
                    w_state_nx = ST_START;
                end else if (r_tick) begin
                    case (r_state)
                        ST_START: w_restart = 1'b1;
                        ST_ON:    w_state_nx = ST_OFF;
                        ST_OFF: begin
                            if (r_pulse_cnt == r_code_lat) begin
                                w_state_nx   = ST_GAP;
                                w_gap_cnt_nx = '0;
                            end else begin
                                w_state_nx     = ST_ON;
                                w_pulse_cnt_nx = r_pulse_cnt + 4'd1;
                            end
                        end
                        ST_GAP: begin
                            if (r_gap_cnt == c_GAP_LAST) begin
                                w_restart = 1'b1;
                            end else begin
                                w_gap_cnt_nx = r_gap_cnt + c_GW'(1);
                            end
                        end
                        default:  w_state_nx = ST_START;
                    endcase

                    // Sequence (re)start: the only point where code is sampled.
                    if (w_restart) begin
                        w_code_lat_nx = w_code;
                        if (w_code == 4'd0) begin
                            w_state_nx   = ST_GAP;
                            w_gap_cnt_nx = '0;
                        end else begin
                            w_state_nx     = ST_ON;
                            w_pulse_cnt_nx = 4'd1;
                        end
                    end
                end
            end

            always_comb begin
                w_led_nx = 1'b0;
                case (w_mode)
                    2'b00:   w_led_nx = 1'b0;
                    2'b01:   w_led_nx = 1'b1;
                    2'b10:   w_led_nx = ~r_phase[2];
                    default: w_led_nx = (r_state == ST_ON);
                endcase
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_state     <= ST_START;
                    r_pulse_cnt <= '0;
                    r_code_lat  <= '0;
                    r_gap_cnt   <= '0;
                    r_led       <= 1'b0;
                end else begin
                    r_state     <= w_state_nx;
                    r_pulse_cnt <= w_pulse_cnt_nx;
                    r_code_lat  <= w_code_lat_nx;
                    r_gap_cnt   <= w_gap_cnt_nx;
                    r_led       <= w_led_nx;
                end
            end

            assign led[gi] = r_led;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debug_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_led_pattern_gen
// Brief    : Self-checking bench for debug_led_pattern_gen (DIV = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_led_pattern_gen;

    localparam int DIV = 8;
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  mode_v = '0;
    logic [15:0] code_v = '0;
    logic [3:0]  led;
    logic        tick;

    int checks = 0;
    int errors = 0;

    // Reference model: tick count since reset and per-channel sequence position.
    int          tick_n = 0;
    int          seq_len [4];
    int          seq_pos [4];
    int          seq_code[4];
    bit          seq_act [4];
    logic [3:0]  exp_led = '0;
    logic [13:0] pat3 = 14'b00000000010101;

    debug_led_pattern_gen #(
        .CLK_HZ    (16),
        .TICK_HZ   (2),
        .N_LEDS    (4),
        .GAP_TICKS (GAP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode_v),
        .code    (code_v),
        .led     (led),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        tick_n = 0;
        for (int ch = 0; ch < 4; ch++) begin
            seq_act[ch] = 1'b0;
            seq_pos[ch] = 0;
            seq_len[ch] = 0;
        end
    endtask

    task automatic model_tick();
        logic [1:0] m;
        tick_n++;
        for (int ch = 0; ch < 4; ch++) begin
            m = mode_v[2*ch +: 2];
            if (m == 2'b00) begin
                exp_led[ch] = 1'b0;
                seq_act[ch] = 1'b0;
            end else if (m == 2'b01) begin
                exp_led[ch] = 1'b1;
                seq_act[ch] = 1'b0;
            end else if (m == 2'b10) begin
                exp_led[ch] = ((tick_n % 8) < 4);
                seq_act[ch] = 1'b0;
            end else begin
                if (!seq_act[ch] || seq_pos[ch] >= seq_len[ch]) begin
                    seq_code[ch] = int'(code_v[4*ch +: 4]);
                    seq_len[ch]  = 2 * seq_code[ch] + GAP;
                    seq_pos[ch]  = 0;
                    seq_act[ch]  = 1'b1;
                end
                exp_led[ch] = (seq_pos[ch] < 2 * seq_code[ch]) && (seq_pos[ch] % 2 == 0);
                seq_pos[ch]++;
            end
        end
    endtask

    // Wait for the next tick, then move to a sampling point where the LED
    // reflects that tick's update; stimulus changes are made from here.
    task automatic advance_slot();
        int waited = 0;
        while (tick !== 1'b1 && waited < 2 * DIV) begin
            @(negedge clk);
            waited++;
        end
        if (tick !== 1'b1) begin
            $display("FAIL tick_timeout: tick=%b required 1 within %0d cycles", tick, 2 * DIV);
            errors++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_tick();
    endtask

    task automatic test_reset();
        mode_v  = '0;
        code_v  = '0;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (led !== 4'b0000 || tick !== 1'b0) begin
                $display("FAIL reset_hold: led=%b tick=%b required led=0000 tick=0", led, tick);
                errors++;
            end
        end
        reset_n = 1'b1;
        model_clear();
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (tick !== (k >= 8 && k % 8 == 0)) begin
                $display("FAIL tick_edge%0d: tick=%b required %b", k, tick, (k >= 8 && k % 8 == 0));
                errors++;
            end
        end
        tick_n = 3;
    endtask

    task automatic test_static_modes();
        mode_v = {2'b11, 2'b10, 2'b01, 2'b00};
        code_v = '0;
        for (int s = 0; s < 20; s++) begin
            advance_slot();
            checks++;
            if (led !== exp_led) begin
                $display("FAIL static slot%0d: led=%b required %b", s, led, exp_led);
                errors++;
            end
        end
    endtask

    task automatic test_blink_code();
        int   rises = 0;
        logic prev = 1'b0;
        mode_v = {2'b10, 2'b01, 2'b00, 2'b11};
        code_v = 16'h0003;
        for (int s = 0; s < 28; s++) begin
            advance_slot();
            checks++;
            if (led !== exp_led || led[0] !== pat3[s % 14]) begin
                $display("FAIL code3 slot%0d: led=%b required %b (led0 %b)", s, led, exp_led, pat3[s % 14]);
                errors++;
            end
            if (led[0] && !prev) rises++;
            prev = led[0];
            if (s % 14 == 13) begin
                checks++;
                if (rises != 3) begin
                    $display("FAIL code3_pulses: counted %0d required 3", rises);
                    errors++;
                end
                rises = 0;
            end
        end
    endtask

    task automatic test_code_change();
        int   rises = 0;
        logic prev = 1'b0;
        mode_v[1:0] = 2'b00;
        advance_slot();
        mode_v[1:0] = 2'b11;
        code_v[3:0] = 4'd3;
        for (int s = 0; s < 32; s++) begin
            advance_slot();
            checks++;
            if (led !== exp_led) begin
                $display("FAIL code_change slot%0d: led=%b required %b", s, led, exp_led);
                errors++;
            end
            if (s == 2) code_v[3:0] = 4'd5;
            if (led[0] && !prev) rises++;
            prev = led[0];
            if (s == 13 || s == 31) begin
                checks++;
                if (rises != ((s == 13) ? 3 : 5)) begin
                    $display("FAIL code_change_pulses: counted %0d required %0d", rises, (s == 13) ? 3 : 5);
                    errors++;
                end
                rises = 0;
            end
        end
    endtask

    task automatic test_mode_change();
        mode_v = {2'b10, 2'b01, 2'b00, 2'b11};
        code_v[3:0] = 4'd3;
        for (int s = 0; s < 3; s++) advance_slot();
        mode_v[1:0] = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (led[0] !== 1'b1) begin
            $display("FAIL mode01_latency: led0=%b required 1", led[0]);
            errors++;
        end
        for (int s = 0; s < 3; s++) begin
            advance_slot();
            checks++;
            if (led !== exp_led) begin
                $display("FAIL mode01 slot%0d: led=%b required %b", s, led, exp_led);
                errors++;
            end
        end
        mode_v[1:0] = 2'b11;
        for (int s = 0; s < 14; s++) begin
            advance_slot();
            checks++;
            if (led !== exp_led || led[0] !== pat3[s]) begin
                $display("FAIL mode_return slot%0d: led=%b required %b (led0 %b)", s, led, exp_led, pat3[s]);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        advance_slot();
        while (exp_led[0] !== 1'b1 && guard < 20) begin
            advance_slot();
            guard++;
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (led !== 4'b0000) begin
            $display("FAIL reset_mid_led: led=%b required 0000", led);
            errors++;
        end
        reset_n = 1'b1;
        model_clear();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (tick !== (k == 8)) begin
                $display("FAIL reset_mid_tick edge%0d: tick=%b required %b", k, tick, (k == 8));
                errors++;
            end
        end
        for (int s = 0; s < 14; s++) begin
            advance_slot();
            checks++;
            if (led !== exp_led || led[0] !== pat3[s]) begin
                $display("FAIL reset_mid slot%0d: led=%b required %b (led0 %b)", s, led, exp_led, pat3[s]);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        int ch;
        for (int s = 0; s < 80; s++) begin
            advance_slot();
            checks++;
            if (led !== exp_led) begin
                $display("FAIL random slot%0d: led=%b required %b mode=%b code=%h", s, led, exp_led, mode_v, code_v);
                errors++;
            end
            if ($urandom_range(0, 3) == 0) begin
                ch = int'($urandom_range(0, 3));
                mode_v[2*ch +: 2] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 2) == 0) begin
                ch = int'($urandom_range(0, 3));
                code_v[4*ch +: 4] = 4'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        test_reset();
        test_static_modes();
        test_blink_code();
        test_code_change();
        test_mode_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_led_pattern_gen.md
# debug_led_pattern_gen

Parametrised multi-channel debug LED driver for the test board. It divides the board clock down to a slow base tick. Each of N_LEDS outputs is then driven in one of four per-channel modes: off, on, 1 Hz-class blink, or blink-code. Blink-code flashes a 4-bit count so firmware or FPGA logic can report a status number on a single LED. It sits at the FPGA top level, between status/control logic and the LED pins.

## Interface
- CLK_HZ, 1_000_000, input clock frequency in Hz
- TICK_HZ, 8, base tick rate in Hz; DIV = CLK_HZ/TICK_HZ, must be ≥ 2 and an exact integer
- N_LEDS, 4, number of LED channels
- GAP_TICKS, 8, dark ticks between blink-code sequences, must be ≥ 1

Ports:
- clk  in  1  board clock; all logic on posedge
- reset_n  in  1  synchronous reset, active-low
- mode  in  2*N_LEDS  channel i uses mode[2i+1:2i]: 00 off, 01 on, 10 blink, 11 blink-code
- code  in  4*N_LEDS  channel i uses code[4i+3:4i]: pulse count for blink-code mode
- led  out  N_LEDS  registered LED drive, 1 = lit
- tick  out  1  registered base-tick strobe, one clk wide

## Operation
Reset (reset_n low at a posedge):
- prescaler = 0, tick = 0, phase = 0, led = 0.
- All channel FSMs go to START, with pulse_cnt = 0, code_lat = 0 and gap_cnt = 0.

Prescaler and tick:
- The prescaler counts 0..DIV-1 and wraps. Its width is $clog2(DIV).
- tick <= (prescaler == DIV-1).

Phase:
- phase is a 3-bit counter shared by all channels. It increments on every cycle with tick = 1 and wraps 7 → 0.

Mode 00 and mode 01:
- Mode 00 sets led[i] <= 0.
- Mode 01 sets led[i] <= 1.

Mode 10 (blink):
- led[i] <= (phase < 4), giving 4 ticks lit and 4 ticks dark. The period is 8 ticks, which is 1 Hz at defaults.
- All blinking channels are in phase with each other.

Mode 11 (blink-code), per-channel FSM with states START, ON, OFF and GAP:
- Whenever mode[i] != 11, the FSM is forced to START on the next cycle, regardless of tick.
- Transitions below occur only on cycles with tick = 1 and mode[i] = 11:
  - START: set code_lat <= code[i]. If code[i] == 0, go to GAP with gap_cnt <= 0. Otherwise go to ON with pulse_cnt <= 1.
  - ON → OFF.
  - OFF: if pulse_cnt == code_lat, go to GAP with gap_cnt <= 0. Otherwise go to ON with pulse_cnt <= pulse_cnt + 1.
  - GAP: if gap_cnt == GAP_TICKS-1, do exactly what START does (relatch code, go to ON or GAP). Otherwise gap_cnt <= gap_cnt + 1.
- led[i] <= (state == ON).
- code[i] is sampled only on the START/GAP-exit tick. Changes made mid-sequence take effect at the next sequence.
- code = 0 keeps the channel permanently dark.

Other rules:
- Channels are fully independent apart from the shared prescaler and phase.
- Mode changes take effect on led at the second posedge after the change.
- Reset asserted mid-sequence returns every channel to START with led = 0 on the next posedge.

## Timing
- After reset_n rises, edge k is the k-th posedge with reset_n high.
- The prescaler reaches DIV-1 at edge DIV-1, so tick = 1 during the cycle after edge DIV. After that, tick pulses every DIV cycles.
- phase and FSM state update at the edge that samples tick = 1. led reflects that update one edge later, so LED latency from tick is 2 edges.
- Blink-code sequence length for code k ≥ 1 is 2k + GAP_TICKS ticks: k lit ticks, each followed by a dark tick, then GAP_TICKS dark ticks.
- The first lit tick begins one tick after entering mode 11, because of the START tick.
- No combinational path from any input to any output.

## Test plan
Bench parameters for all scenarios: CLK_HZ = 16, TICK_HZ = 2 (DIV = 8), N_LEDS = 4, GAP_TICKS = 8.

1. Reset and tick:
   - Stimulus: hold reset_n low for 3 cycles, then release.
   - Required: led = 0 and tick = 0 during reset; tick first high after edge 8, then every 8 cycles exactly 1 cycle wide.
2. Static modes:
   - Stimulus: mode = {11,10,01,00} (ch3..ch0) with code = 0 for all channels.
   - Required: ch0 = 0 and ch1 = 1 constantly; ch2 repeats 4 ticks lit, 4 ticks dark; ch3 = 0 always (code = 0).
3. Blink-code, code = 3 on ch0:
   - Required: led[0] pattern per tick after the START tick is 1,0,1,0,1,0 followed by 8 zeros, repeating.
   - Required: exactly 3 rising edges per 14-tick sequence.
4. Code change mid-sequence:
   - Stimulus: code 3 → 5 during the second pulse.
   - Required: current sequence still gives 3 pulses; the next sequence gives 5 pulses.
5. Mode change mid-sequence:
   - Stimulus: set ch0 mode 11 → 01 → 11.
   - Required: led[0] = 1 two edges after the change to 01; on return to 11, one START tick, then a fresh sequence starting at pulse 1.
6. Reset mid-sequence:
   - Stimulus: pull reset_n low while in the ON state.
   - Required: led = 0 the next edge; prescaler restarts; the first tick lands after edge 8 again.
